// File: rtl/i2c_reg_slave.sv
// i2c_reg_slave
//   I2C target with a small 8-bit register file. A write transfer sets the
//   register pointer with its first data byte and then writes successive
//   registers. A read transfer returns registers starting at the pointer.
//   The pointer auto-increments modulo NREG and survives a repeated START.
//   SCL and SDA are sampled through 2-flop synchronizers plus a history flop.
//   The slave never stretches SCL.
//
// Ports
//   clk      system clock (at least 16x the SCL frequency)
//   rst      synchronous active-high reset
//   scl_i    raw SCL from the pad, asynchronous to clk
//   sda_i    raw SDA from the pad, asynchronous to clk
//   sda_oe   1 pulls SDA low, 0 releases it (open-drain pad is external)
//   reg_out  register file, register k at bits [8k+7:8k]
//   wr_stb   one-clk pulse when a register is written
//   wr_addr  index of the written register, valid while wr_stb=1
//   busy     1 from START to STOP, whether or not the address matched
module i2c_reg_slave #(
    parameter logic [6:0] I2C_ADR = 7'h70,
    parameter int         NREG    = 4,
    parameter logic [7:0] RST_VAL = 8'hFF,
    localparam int        AW      = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_oe,
    output logic [NREG*8-1:0] reg_out,
    output logic              wr_stb,
    output logic [AW-1:0]     wr_addr,
    output logic              busy
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_IGNORE
    } state_t;

    state_t        r_state, w_state_next;
    logic          r_scl_s1, r_scl_s2, r_scl_h;
    logic          r_sda_s1, r_sda_s2, r_sda_h;
    logic          w_scl_rise, w_scl_fall, w_start, w_stop, w_sda;
    logic [7:0]    w_byte;
    logic [7:0]    r_shift;
    logic [3:0]    r_bitcnt;
    logic          r_ack_ph;     // 0: before the ACK-drive fall, 1: ACK slot in progress
    logic          r_rw;
    logic [AW-1:0] r_ptr, w_ptr_inc;
    logic [7:0]    r_regs [NREG];
    logic          r_sda_oe, r_wr_stb, r_busy;
    logic [AW-1:0] r_wr_addr;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking (=) here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            {r_scl_s1, r_scl_s2, r_scl_h} <= 3'b111;
            {r_sda_s1, r_sda_s2, r_sda_h} <= 3'b111;
        end else begin
            {r_scl_s1, r_scl_s2, r_scl_h} <= {scl_i, r_scl_s1, r_scl_s2};
            {r_sda_s1, r_sda_s2, r_sda_h} <= {sda_i, r_sda_s1, r_sda_s2};
        end
    end

    // Edge events are decoded from the synchronized value and its history,
    // so they are acted on exactly 3 clk after the pin edge.
    assign w_scl_rise = r_scl_s2 & ~r_scl_h;
    assign w_scl_fall = ~r_scl_s2 & r_scl_h;
    assign w_start    = r_scl_s2 & r_scl_h & ~r_sda_s2 & r_sda_h;
    assign w_stop     = r_scl_s2 & r_scl_h & r_sda_s2 & ~r_sda_h;
    assign w_sda      = r_sda_s2;
    assign w_byte     = {r_shift[6:0], w_sda};  // byte completed by the current rise
    assign w_ptr_inc  = r_ptr + AW'(1);          // wraps naturally: NREG is a power of 2

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // NOTE: the default assignment first keeps this block free of inferred
    // latches on paths that do not change state.
    always_comb begin
        w_state_next = r_state;
        if (w_start) begin
            w_state_next = S_ADDR;
        end else if (w_stop) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_ADDR:      if (w_scl_rise && r_bitcnt == 4'd0)
                                 w_state_next = (w_byte[7:1] == I2C_ADR) ? S_ADDR_ACK : S_IGNORE;
                S_ADDR_ACK:  if (w_scl_fall && r_ack_ph)
                                 w_state_next = r_rw ? S_RDATA : S_PTR;
                S_PTR:       if (w_scl_rise && r_bitcnt == 4'd0) w_state_next = S_PTR_ACK;
                S_PTR_ACK:   if (w_scl_fall && r_ack_ph) w_state_next = S_WDATA;
                S_WDATA:     if (w_scl_rise && r_bitcnt == 4'd0) w_state_next = S_WDATA_ACK;
                S_WDATA_ACK: if (w_scl_fall && r_ack_ph) w_state_next = S_WDATA;
                S_RDATA:     if (w_scl_rise && r_bitcnt == 4'd1) w_state_next = S_RDATA_ACK;
                S_RDATA_ACK: if (w_scl_rise && r_ack_ph)
                                 w_state_next = w_sda ? S_IGNORE : S_RDATA;
                default:     ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift   <= 8'h00;
            r_bitcnt  <= 4'd0;
            r_ack_ph  <= 1'b0;
            r_rw      <= 1'b0;
            r_ptr     <= '0;
            r_sda_oe  <= 1'b0;
            r_wr_stb  <= 1'b0;
            r_wr_addr <= '0;
            r_busy    <= 1'b0;
            // NOTE: the register file is a handful of flops with a defined
            // reset value, not a RAM, so it is reset like any other state.
            for (int k = 0; k < NREG; k++) r_regs[k] <= RST_VAL;
        end else begin
            r_wr_stb <= 1'b0;
            if (w_start) begin
                r_busy   <= 1'b1;
                r_bitcnt <= 4'd7;
                r_ack_ph <= 1'b0;
            end else if (w_stop) begin
                r_busy   <= 1'b0;
                r_sda_oe <= 1'b0;
            end else begin
                case (r_state)
                    S_ADDR, S_PTR, S_WDATA: begin
                        if (w_scl_fall) r_sda_oe <= 1'b0;
                        if (w_scl_rise) begin
                            r_shift  <= w_byte;
                            r_bitcnt <= r_bitcnt - 4'd1;
                            r_ack_ph <= 1'b0;
                            if (r_bitcnt == 4'd0) begin
                                if (r_state == S_ADDR) r_rw  <= w_sda;
                                if (r_state == S_PTR)  r_ptr <= w_byte[AW-1:0];
                                if (r_state == S_WDATA) begin
                                    r_regs[r_ptr] <= w_byte;
                                    r_wr_stb      <= 1'b1;
                                    r_wr_addr     <= r_ptr;
                                    r_ptr         <= w_ptr_inc;
                                end
                            end
                        end
                    end
                    S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
                        // First fall starts the ACK pulse, second fall ends it.
                        if (w_scl_fall) begin
                            if (!r_ack_ph) begin
                                r_sda_oe <= 1'b1;
                                r_ack_ph <= 1'b1;
                            end else begin
                                r_ack_ph <= 1'b0;
                                r_bitcnt <= 4'd7;
                                if (r_state == S_ADDR_ACK && r_rw) begin
                                    // Read: the first data bit goes out on this same fall.
                                    r_shift  <= {r_regs[r_ptr][6:0], 1'b0};
                                    r_sda_oe <= ~r_regs[r_ptr][7];
                                    r_bitcnt <= 4'd8;
                                end else begin
                                    r_sda_oe <= 1'b0;
                                end
                            end
                        end
                    end
                    S_RDATA: begin
                        // r_bitcnt counts the rises still to come for this byte.
                        if (w_scl_fall) begin
                            r_sda_oe <= ~r_shift[7];
                            r_shift  <= {r_shift[6:0], 1'b0};
                        end
                        if (w_scl_rise) begin
                            r_bitcnt <= r_bitcnt - 4'd1;
                            r_ack_ph <= 1'b0;
                        end
                    end
                    S_RDATA_ACK: begin
                        if (w_scl_fall && !r_ack_ph) begin
                            r_sda_oe <= 1'b0;
                            r_ack_ph <= 1'b1;
                        end
                        if (w_scl_rise && r_ack_ph && !w_sda) begin
                            // Master ACK: the next byte is driven from the following fall.
                            r_ptr    <= w_ptr_inc;
                            r_shift  <= r_regs[w_ptr_inc];
                            r_bitcnt <= 4'd8;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        reg_out = '0;
        for (int k = 0; k < NREG; k++) reg_out[8*k +: 8] = r_regs[k];
    end

    assign sda_oe  = r_sda_oe;
    assign wr_stb  = r_wr_stb;
    assign wr_addr = r_wr_addr;
    assign busy    = r_busy;

endmodule

// File: tb/tb_i2c_reg_slave.sv
// tb_i2c_reg_slave
//   Bit-banged I2C master driving i2c_reg_slave, with a register-file model
//   (array + pointer) that predicts read data, write strobes and reg_out.
module tb_i2c_reg_slave;

    localparam int         NREG = 4;
    localparam int         AW   = 2;
    localparam logic [6:0] ADR  = 7'h70;
    localparam int         Q    = 50;   // quarter SCL period: SCL = 20 clk

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              m_scl = 1'b1;
    logic              m_sda = 1'b1;
    wire               sda_i;
    logic              sda_oe;
    logic [NREG*8-1:0] reg_out;
    logic              wr_stb;
    logic [AW-1:0]     wr_addr;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Open-drain bus: low if either side pulls it low.
    assign sda_i = m_sda & ~sda_oe;

    i2c_reg_slave #(.I2C_ADR(ADR), .NREG(NREG), .RST_VAL(8'hFF)) dut (
        .clk(clk), .rst(rst), .scl_i(m_scl), .sda_i(sda_i), .sda_oe(sda_oe),
        .reg_out(reg_out), .wr_stb(wr_stb), .wr_addr(wr_addr), .busy(busy)
    );

    always #5 clk = ~clk;

    // Monitors, sampled on the falling clock edge.
    int            wr_cnt = 0;
    int            oe_cnt = 0;
    int            long_cnt = 0;
    logic          prev_stb = 1'b0;
    logic [AW-1:0] wr_log [1024];

    always @(negedge clk) begin
        if (wr_stb === 1'b1) begin
            wr_log[wr_cnt % 1024] = wr_addr;
            wr_cnt++;
            if (prev_stb) long_cnt++;
        end
        prev_stb = (wr_stb === 1'b1);
        if (sda_oe === 1'b1) oe_cnt++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    logic [7:0] m_regs [NREG];
    int         m_ptr;

    task automatic model_reset();
        for (int k = 0; k < NREG; k++) m_regs[k] = 8'hFF;
        m_ptr = 0;
    endtask

    function automatic logic [NREG*8-1:0] model_image();
        logic [NREG*8-1:0] v;
        for (int k = 0; k < NREG; k++) v[8*k +: 8] = m_regs[k];
        return v;
    endfunction

    // ---------------- bus master ----------------
    task automatic clk_bit(input logic b, output logic r);
        m_sda = b; #Q;
        m_scl = 1'b1; #Q;
        r = sda_i; #Q;
        m_scl = 1'b0; #Q;
    endtask

    task automatic bus_start();
        m_sda = 1'b1; #Q;
        m_scl = 1'b1; #Q;
        m_sda = 1'b0; #Q;
        m_scl = 1'b0; #Q;
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; #Q;
        m_scl = 1'b1; #Q;
        m_sda = 1'b1; #Q;
    endtask

    task automatic send_byte(input logic [7:0] v, output logic acked);
        logic r;
        for (int i = 7; i >= 0; i--) clk_bit(v[i], r);
        clk_bit(1'b1, r);
        acked = (r == 1'b0);
    endtask

    task automatic recv_byte(input logic ack, output logic [7:0] v);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, r);
            v[i] = r;
        end
        clk_bit(~ack, r);
    endtask

    // Full write transfer; updates the model and counts missing ACKs.
    task automatic m_write(input logic [7:0] ptr, input int n, input logic [7:0] d [3],
                           output int nacks);
        logic a;
        nacks = 0;
        bus_start();
        send_byte({ADR, 1'b0}, a); if (!a) nacks++;
        send_byte(ptr, a);         if (!a) nacks++;
        for (int i = 0; i < n; i++) begin
            send_byte(d[i], a); if (!a) nacks++;
        end
        bus_stop();
        m_ptr = int'(ptr) % NREG;
        for (int i = 0; i < n; i++) begin
            m_regs[m_ptr] = d[i];
            m_ptr = (m_ptr + 1) % NREG;
        end
    endtask

    // Read transfer, optionally setting the pointer first via repeated START.
    task automatic m_read(input logic set_ptr, input logic [7:0] ptr, input int n,
                          output logic [7:0] got [3], output logic [7:0] exp [3],
                          output int nacks, output logic oe_end);
        logic a;
        nacks = 0;
        for (int i = 0; i < 3; i++) begin got[i] = 8'h00; exp[i] = 8'h00; end
        bus_start();
        if (set_ptr) begin
            send_byte({ADR, 1'b0}, a); if (!a) nacks++;
            send_byte(ptr, a);         if (!a) nacks++;
            bus_start();
            m_ptr = int'(ptr) % NREG;
        end
        send_byte({ADR, 1'b1}, a); if (!a) nacks++;
        for (int i = 0; i < n; i++) begin
            recv_byte(i < n - 1, got[i]);
            exp[i] = m_regs[(m_ptr + i) % NREG];
        end
        oe_end = sda_oe;
        bus_stop();
        m_ptr = (m_ptr + n - 1) % NREG;
    endtask

    // Transfer to a foreign address; the slave must stay silent.
    task automatic m_bad(input logic [6:0] a7, input int n, input logic [7:0] d [3],
                         output int acks, output logic busy_mid);
        logic a;
        acks = 0;
        bus_start();
        send_byte({a7, 1'b0}, a); if (a) acks++;
        for (int i = 0; i < n; i++) begin
            send_byte(d[i], a); if (a) acks++;
        end
        busy_mid = busy;
        bus_stop();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        model_reset();
        n_tests++; if (reg_out !== model_image()) begin n_fail++; $display("FAIL reset_regs: got %h expected %h", reg_out, model_image()); end
        n_tests++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL reset_sda_oe: got %b expected 0", sda_oe); end
        n_tests++; if (wr_stb !== 1'b0) begin n_fail++; $display("FAIL reset_wr_stb: got %b expected 0", wr_stb); end
        n_tests++; if (wr_addr !== '0) begin n_fail++; $display("FAIL reset_wr_addr: got %0d expected 0", wr_addr); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_write();
        logic [7:0] d [3];
        int nacks, base;
        d[0] = 8'hA5; d[1] = 8'h3C; d[2] = 8'h00;
        base = wr_cnt;
        m_write(8'h01, 2, d, nacks);
        n_tests++; if (nacks !== 0) begin n_fail++; $display("FAIL write_acks: got %0d missing ACKs expected 0", nacks); end
        n_tests++; if (reg_out[15:8] !== 8'hA5) begin n_fail++; $display("FAIL write_reg1: got %h expected a5", reg_out[15:8]); end
        n_tests++; if (reg_out[23:16] !== 8'h3C) begin n_fail++; $display("FAIL write_reg2: got %h expected 3c", reg_out[23:16]); end
        n_tests++; if (reg_out !== model_image()) begin n_fail++; $display("FAIL write_image: got %h expected %h", reg_out, model_image()); end
        n_tests++; if (wr_cnt - base !== 2) begin n_fail++; $display("FAIL write_stb_count: got %0d expected 2", wr_cnt - base); end
        n_tests++; if (wr_log[base % 1024] !== 2'd1) begin n_fail++; $display("FAIL write_addr0: got %0d expected 1", wr_log[base % 1024]); end
        n_tests++; if (wr_log[(base + 1) % 1024] !== 2'd2) begin n_fail++; $display("FAIL write_addr1: got %0d expected 2", wr_log[(base + 1) % 1024]); end
        n_tests++; if (long_cnt !== 0) begin n_fail++; $display("FAIL write_stb_width: got %0d long pulses expected 0", long_cnt); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL write_busy_after_stop: got %b expected 0", busy); end
    endtask

    task automatic test_wrap();
        logic [7:0] d [3];
        logic [7:0] got [3];
        logic [7:0] exp [3];
        int nacks;
        logic oe_end;
        d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h00;
        m_write(8'h03, 2, d, nacks);
        n_tests++; if (nacks !== 0) begin n_fail++; $display("FAIL wrap_acks: got %0d missing ACKs expected 0", nacks); end
        n_tests++; if (reg_out[31:24] !== 8'h11) begin n_fail++; $display("FAIL wrap_reg3: got %h expected 11", reg_out[31:24]); end
        n_tests++; if (reg_out[7:0] !== 8'h22) begin n_fail++; $display("FAIL wrap_reg0: got %h expected 22", reg_out[7:0]); end
        // Pointer should now be 1: a read from the current pointer returns reg1.
        m_read(1'b0, 8'h00, 1, got, exp, nacks, oe_end);
        n_tests++; if (got[0] !== exp[0]) begin n_fail++; $display("FAIL wrap_ptr_read: got %h expected %h", got[0], exp[0]); end
    endtask

    task automatic test_rep_start_read();
        logic [7:0] got [3];
        logic [7:0] exp [3];
        int nacks;
        logic oe_end;
        m_read(1'b1, 8'h02, 2, got, exp, nacks, oe_end);
        n_tests++; if (nacks !== 0) begin n_fail++; $display("FAIL rs_acks: got %0d missing ACKs expected 0", nacks); end
        n_tests++; if (got[0] !== 8'h3C) begin n_fail++; $display("FAIL rs_byte0: got %h expected 3c", got[0]); end
        n_tests++; if (got[1] !== exp[1]) begin n_fail++; $display("FAIL rs_byte1: got %h expected %h", got[1], exp[1]); end
        n_tests++; if (oe_end !== 1'b0) begin n_fail++; $display("FAIL rs_oe_after_nack: got %b expected 0", oe_end); end
    endtask

    task automatic test_no_match();
        logic [7:0] d [3];
        int acks, base_wr, base_oe;
        logic busy_mid;
        d[0] = 8'h00; d[1] = 8'h55; d[2] = 8'h00;
        base_wr = wr_cnt; base_oe = oe_cnt;
        m_bad(7'h71, 2, d, acks, busy_mid);
        n_tests++; if (acks !== 0) begin n_fail++; $display("FAIL nomatch_acks: got %0d expected 0", acks); end
        n_tests++; if (oe_cnt - base_oe !== 0) begin n_fail++; $display("FAIL nomatch_oe: got %0d clk of sda_oe expected 0", oe_cnt - base_oe); end
        n_tests++; if (wr_cnt - base_wr !== 0) begin n_fail++; $display("FAIL nomatch_wr_stb: got %0d expected 0", wr_cnt - base_wr); end
        n_tests++; if (reg_out !== model_image()) begin n_fail++; $display("FAIL nomatch_regs: got %h expected %h", reg_out, model_image()); end
        n_tests++; if (busy_mid !== 1'b1) begin n_fail++; $display("FAIL nomatch_busy_mid: got %b expected 1", busy_mid); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL nomatch_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_stop_mid_and_reset();
        logic [7:0] d [3];
        logic a, r;
        int nacks, base;
        // STOP after 4 data bits: pointer is set, partial byte discarded.
        base = wr_cnt;
        bus_start();
        send_byte({ADR, 1'b0}, a);
        send_byte(8'h00, a);
        for (int i = 0; i < 4; i++) clk_bit(1'b0, r);
        bus_stop();
        m_ptr = 0;
        n_tests++; if (wr_cnt - base !== 0) begin n_fail++; $display("FAIL stopmid_wr_stb: got %0d expected 0", wr_cnt - base); end
        n_tests++; if (reg_out !== model_image()) begin n_fail++; $display("FAIL stopmid_regs: got %h expected %h", reg_out, model_image()); end
        // Reset in the middle of a second write's data byte.
        bus_start();
        send_byte({ADR, 1'b0}, a);
        send_byte(8'h01, a);
        for (int i = 0; i < 3; i++) clk_bit(1'b0, r);
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        model_reset();
        n_tests++; if (reg_out !== model_image()) begin n_fail++; $display("FAIL rst_mid_regs: got %h expected %h", reg_out, model_image()); end
        n_tests++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL rst_mid_oe: got %b expected 0", sda_oe); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        // Next START decodes normally.
        d[0] = 8'h77; d[1] = 8'h00; d[2] = 8'h00;
        m_write(8'h02, 1, d, nacks);
        n_tests++; if (nacks !== 0) begin n_fail++; $display("FAIL post_rst_acks: got %0d missing ACKs expected 0", nacks); end
        n_tests++; if (reg_out !== model_image()) begin n_fail++; $display("FAIL post_rst_regs: got %h expected %h", reg_out, model_image()); end
    endtask

    task automatic test_random();
        logic [7:0] d [3];
        logic [7:0] got [3];
        logic [7:0] exp [3];
        logic [7:0] ptr;
        logic [6:0] badr;
        logic [AW-1:0] ea;
        logic oe_end, busy_mid;
        int op, n, nacks, base, base_oe;
        for (int it = 0; it < 16; it++) begin
            op  = $urandom_range(0, 2);
            n   = $urandom_range(1, 3);
            ptr = 8'($urandom);
            for (int i = 0; i < 3; i++) d[i] = 8'($urandom);
            case (op)
                0: begin
                    base = wr_cnt;
                    m_write(ptr, n, d, nacks);
                    n_tests++; if (nacks !== 0) begin n_fail++; $display("FAIL rnd%0d_wr_acks: got %0d expected 0", it, nacks); end
                    n_tests++; if (wr_cnt - base !== n) begin n_fail++; $display("FAIL rnd%0d_wr_count: got %0d expected %0d", it, wr_cnt - base, n); end
                    for (int i = 0; i < n; i++) begin
                        ea = AW'((int'(ptr) + i) % NREG);
                        n_tests++; if (wr_log[(base + i) % 1024] !== ea) begin n_fail++; $display("FAIL rnd%0d_wr_addr%0d: got %0d expected %0d", it, i, wr_log[(base + i) % 1024], ea); end
                    end
                end
                1: begin
                    m_read(1'($urandom_range(0, 1)), ptr, n, got, exp, nacks, oe_end);
                    n_tests++; if (nacks !== 0) begin n_fail++; $display("FAIL rnd%0d_rd_acks: got %0d expected 0", it, nacks); end
                    for (int i = 0; i < n; i++) begin
                        n_tests++; if (got[i] !== exp[i]) begin n_fail++; $display("FAIL rnd%0d_rd_byte%0d: got %h expected %h", it, i, got[i], exp[i]); end
                    end
                    n_tests++; if (oe_end !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_rd_oe: got %b expected 0", it, oe_end); end
                end
                default: begin
                    badr = 7'($urandom_range(0, 127));
                    if (badr == ADR) badr = badr ^ 7'h01;
                    base = wr_cnt; base_oe = oe_cnt;
                    m_bad(badr, n, d, nacks, busy_mid);
                    n_tests++; if (nacks !== 0) begin n_fail++; $display("FAIL rnd%0d_bad_acks: got %0d expected 0", it, nacks); end
                    n_tests++; if (oe_cnt - base_oe !== 0) begin n_fail++; $display("FAIL rnd%0d_bad_oe: got %0d expected 0", it, oe_cnt - base_oe); end
                    n_tests++; if (wr_cnt - base !== 0) begin n_fail++; $display("FAIL rnd%0d_bad_wr: got %0d expected 0", it, wr_cnt - base); end
                end
            endcase
            n_tests++; if (reg_out !== model_image()) begin n_fail++; $display("FAIL rnd%0d_regs: got %h expected %h", it, reg_out, model_image()); end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_wrap();
        test_rep_start_read();
        test_no_match();
        test_stop_mid_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_reg_slave.md
I2C_REG_SLAVE -- requirements
Module: i2c_reg_slave

Interface
REQ-001 Parameter I2C_ADR, default 7'h70: 7-bit slave address.
REQ-002 Parameter NREG, default 4: number of 8-bit registers, power of 2, range 2..16; AW = log2(NREG).
REQ-003 Parameter RST_VAL, default 8'hFF: reset value of every register.
REQ-004 Port clk, input, 1 bit: system clock; the block shall have one clock.
REQ-005 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port scl_i, input, 1 bit: raw I2C SCL, asynchronous to clk.
REQ-007 Port sda_i, input, 1 bit: raw I2C SDA, asynchronous to clk.
REQ-008 Port sda_oe, output, 1 bit: 1 pulls SDA low, 0 releases it; the pad is external.
REQ-009 Port reg_out, output, NREG*8 bits: register file; register k occupies bits [8k+7:8k].
REQ-010 Port wr_stb, output, 1 bit: one-clk pulse when a register is written.
REQ-011 Port wr_addr, output, AW bits: index of the written register, valid while wr_stb=1.
REQ-012 Port busy, output, 1 bit: 1 from START to STOP, whether or not the address matched.

Function
REQ-013 scl_i and sda_i shall each pass through a 2-flop synchronizer, then one history flop for edge detection.
REQ-014 Delay from an SCL/SDA pin edge to its detected event shall be exactly 3 clk; clk shall be at least 16x the SCL frequency.
REQ-015 START = SDA fall with SCL high; STOP = SDA rise with SCL high, both from synchronized values.
REQ-016 START or STOP shall override any state: START goes to ADDR with bitcnt=7; STOP goes to IDLE with sda_oe=0.
REQ-017 SDA shall be sampled on the detected SCL rise; sda_oe shall change only on the detected SCL fall (or STOP/rst).
REQ-018 States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
REQ-019 ADDR: shift 8 bits MSB first. Upper 7 bits == I2C_ADR shall go to ADDR_ACK and drive ACK; a mismatch shall go to IGNORE, which waits for START/STOP.
REQ-020 ADDR_ACK with R/W=0 shall go to PTR; with R/W=1, pre-load the read shifter from reg[ptr] and go to RDATA.
REQ-021 PTR: the received byte's low AW bits shall load ptr (upper bits ignored), then PTR_ACK (ACK), then WDATA.
REQ-022 WDATA: after 8 bits, reg[ptr] <= byte, wr_stb=1 for 1 clk with wr_addr=ptr, then WDATA_ACK (ACK).
REQ-023 After the WDATA write, ptr shall advance to ptr+1 mod NREG, wrapping NREG-1 to 0.
REQ-024 RDATA: on each SCL fall, sda_oe = ~shifter MSB (0 bit pulls low, 1 bit releases); after 8 bits, release and go to RDATA_ACK.
REQ-025 RDATA_ACK: a sampled SDA=0 (master ACK) shall advance ptr mod NREG, load reg[ptr+1], and go to RDATA; SDA=1 (NACK) shall go to IGNORE.
REQ-026 ACK drive: sda_oe=1 from the SCL fall after bit 8 to the next SCL fall.
REQ-027 A repeated START shall keep ptr, so a PTR write followed by repeated START and read addr+R shall read from the written pointer.
REQ-028 reg_out shall update 1 clk after the 8th data bit is sampled; a STOP mid-byte shall discard the partial byte with no write.
REQ-029 The slave shall never stretch SCL.

Reset
REQ-030 rst=1 for 1+ clk shall force: state IDLE, sda_oe=0, wr_stb=0, wr_addr=0, busy=0, ptr=0, every register=RST_VAL, synchronizers to 1.
REQ-031 Reset mid-transfer shall abort the transfer; the block shall ignore the bus until the next START.

Verification
REQ-032 Write 70/W, ptr 01, data A5, 3C, STOP -> reg1=A5, reg2=3C, two wr_stb pulses with wr_addr 1,2, all three ACKs low.
REQ-033 Write 70/W, ptr 03, data 11, 22 (NREG=4) -> reg3=11, reg0=22 (wrap), ptr=1.
REQ-034 70/W, ptr 02, repeated START, 70/R, read 2 bytes ACK then NACK, STOP -> master reads reg2, reg3; sda_oe=0 after NACK.
REQ-035 Address 71/W, ptr 00, data 55 -> no ACK, sda_oe stays 0, no wr_stb, registers unchanged, busy=1 until STOP.
REQ-036 STOP after 4 data bits, then rst asserted mid-write of a second transfer -> no partial write from the STOP; rst leaves every register=FF, sda_oe=0, and the next START is decoded normally.
